// File: rtl/fdn_pkg.sv
// Shared FDN definitions: datapath word width, readout FSM states and index-width helper.
package fdn_pkg;

    localparam int WORD_W = 18;

    typedef enum logic [0:0] {
        RD_IDLE   = 1'b0,
        RD_STREAM = 1'b1
    } rd_state_e;

    // Index width for a node count; never below one bit so a 1-bit port still exists.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fdn_snapshot_bank.sv
// Snapshot storage for all node values plus the word read mux.
module fdn_snapshot_bank
    import fdn_pkg::*;
#(
    parameter int NUM_NODES = 16,
    parameter int IDX_W     = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        load,
    input  logic [WORD_W*NUM_NODES-1:0] din,
    input  logic [IDX_W-1:0]            idx,
    output logic [WORD_W-1:0]           dout
);

    logic [NUM_NODES-1:0][WORD_W-1:0] mem_q, mem_d;

    always_comb begin
        mem_d = mem_q;
        if (load) mem_d = din;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) mem_q <= '0;
        else        mem_q <= mem_d;
    end

    assign dout = mem_q[idx];

endmodule

// File: rtl/node_readout.sv
// Decimating snapshot readout: captures all node values on a grid step and streams them out.
module node_readout
    import fdn_pkg::*;
#(
    parameter int NUM_NODES  = 16,
    parameter int SAMPLE_DIV = 1,
    parameter int TAP_IDX    = NUM_NODES / 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [WORD_W*NUM_NODES-1:0]   u_bus,
    input  logic                          valid_in,
    input  logic                          tap_only,
    output logic [WORD_W-1:0]             out_data,
    output logic [idx_w(NUM_NODES)-1:0]   out_node,
    output logic                          out_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [15:0]                   drop_count
);

    localparam int IDX_W = idx_w(NUM_NODES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NODES - 1);
    localparam logic [IDX_W-1:0] TAP_I    = IDX_W'(TAP_IDX);
    localparam logic [15:0]      DIV_TOP  = 16'(SAMPLE_DIV - 1);

    rd_state_e        state_q, state_d;
    logic [15:0]      dec_q, dec_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             tap_q, tap_d;
    logic [15:0]      drop_q, drop_d;
    logic             load;
    logic             capture;
    logic             hs;
    logic             last;
    logic [WORD_W-1:0] word;

    fdn_snapshot_bank #(
        .NUM_NODES(NUM_NODES),
        .IDX_W    (IDX_W)
    ) u_bank (
        .clk  (clk),
        .reset(reset),
        .load (load),
        .din  (u_bus),
        .idx  (idx_q),
        .dout (word)
    );

    assign capture = valid_in && (dec_q == 16'd0);
    assign last    = tap_q || (idx_q == LAST_IDX);
    assign hs      = (state_q == RD_STREAM) && out_ready;

    always_comb begin
        dec_d   = dec_q;
        state_d = state_q;
        idx_d   = idx_q;
        tap_d   = tap_q;
        drop_d  = drop_q;
        load    = 1'b0;

        if (valid_in) dec_d = (dec_q >= DIV_TOP) ? 16'd0 : dec_q + 16'd1;

        // A capture is accepted when idle or exactly on the final handshake (back-to-back frames).
        if (state_q == RD_IDLE || (hs && last)) begin
            if (capture) begin
                load    = 1'b1;
                tap_d   = tap_only;
                idx_d   = tap_only ? TAP_I : '0;
                state_d = RD_STREAM;
            end else if (state_q == RD_STREAM) begin
                state_d = RD_IDLE;
                idx_d   = '0;
            end
        end else begin
            if (hs) idx_d = idx_q + 1'b1;
            if (capture && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RD_IDLE;
            dec_q   <= '0;
            idx_q   <= '0;
            tap_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            dec_q   <= dec_d;
            idx_q   <= idx_d;
            tap_q   <= tap_d;
            drop_q  <= drop_d;
        end
    end

    assign out_valid  = (state_q == RD_STREAM);
    assign out_last   = out_valid && last;
    assign out_data   = out_valid ? word : '0;
    assign out_node   = out_valid ? idx_q : '0;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_node_readout.sv
// Scoreboard bench: stimulus pushes expected words, negedge monitors pop on each handshake.
module tb_node_readout;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [71:0] u_bus = '0;

    logic        vin_a = 1'b0, tap_a = 1'b0, rdy_a = 1'b0;
    logic [17:0] data_a;
    logic [1:0]  node_a;
    logic        last_a, val_a;
    logic [15:0] drop_a;

    logic        vin_b = 1'b0, tap_b = 1'b1, rdy_b = 1'b1;
    logic [17:0] data_b;
    logic [1:0]  node_b;
    logic        last_b, val_b;
    logic [15:0] drop_b;

    typedef struct {
        logic [1:0]  node;
        logic [17:0] data;
        logic        last;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    node_readout #(.NUM_NODES(4), .SAMPLE_DIV(1)) dut_a (
        .clk(clk), .reset(reset), .u_bus(u_bus), .valid_in(vin_a), .tap_only(tap_a),
        .out_data(data_a), .out_node(node_a), .out_last(last_a), .out_valid(val_a),
        .out_ready(rdy_a), .drop_count(drop_a)
    );

    node_readout #(.NUM_NODES(4), .SAMPLE_DIV(3), .TAP_IDX(2)) dut_b (
        .clk(clk), .reset(reset), .u_bus(u_bus), .valid_in(vin_b), .tap_only(tap_b),
        .out_data(data_b), .out_node(node_b), .out_last(last_b), .out_valid(val_b),
        .out_ready(rdy_b), .drop_count(drop_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_a(input logic [1:0] n, input logic [17:0] d, input logic l);
        exp_t e;
        e.node = n; e.data = d; e.last = l;
        qa.push_back(e);
    endtask

    task automatic push_frame_a(input logic [71:0] bus);
        for (int k = 0; k < 4; k++) push_a(2'(k), bus[18*k +: 18], k == 3);
    endtask

    task automatic push_b(input logic [17:0] d);
        exp_t e;
        e.node = 2'd2; e.data = d; e.last = 1'b1;
        qb.push_back(e);
    endtask

    task automatic pulse_a();
        vin_a = 1'b1;
        @(posedge clk); #1;
        vin_a = 1'b0;
    endtask

    task automatic drain_a(input string name);
        for (int i = 0; i < 50; i++) begin
            if (qa.size() == 0 && !val_a) break;
            @(posedge clk); #1;
        end
        chk(name, 32'(qa.size()), 32'd0);
        chk({name, "_idle"}, 32'(val_a), 32'd0);
    endtask

    always @(negedge clk) begin
        if (reset && val_a && rdy_a) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_word", {14'd0, node_a, data_a[15:0]}, 32'hFFFFFFFF);
            end else begin
                exp_t e;
                e = qa.pop_front();
                chk("a_node", 32'(node_a), 32'(e.node));
                chk("a_data", 32'(data_a), 32'(e.data));
                chk("a_last", 32'(last_a), 32'(e.last));
            end
        end
    end

    always @(negedge clk) begin
        if (reset && val_b && rdy_b) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_word", {14'd0, node_b, data_b[15:0]}, 32'hFFFFFFFF);
            end else begin
                exp_t e;
                e = qb.pop_front();
                chk("b_node", 32'(node_b), 32'(e.node));
                chk("b_data", 32'(data_b), 32'(e.data));
                chk("b_last", 32'(last_b), 32'(e.last));
            end
        end
    end

    localparam logic [71:0] BUS_A = {18'h3_0000, 18'h0_8000, 18'h0_0001, 18'h1_FFFF};
    localparam logic [71:0] BUS_B = {18'h2_AAAA, 18'h1_5555, 18'h0_1234, 18'h3_FFFF};
    localparam logic [71:0] BUS_C = {18'h0_0C0C, 18'h0_0B0B, 18'h0_0A0A, 18'h0_0909};
    localparam logic [71:0] BUS_D = {18'h2_0000, 18'h1_0000, 18'h0_4000, 18'h0_0002};

    initial begin
        logic [17:0] tap_vals [6];
        tap_vals = '{18'h0_0111, 18'h0_0222, 18'h0_0333, 18'h2_0444, 18'h0_0555, 18'h0_0666};

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(val_a), 32'd0);
        chk("rst_last", 32'(last_a), 32'd0);
        chk("rst_data", 32'(data_a), 32'd0);
        chk("rst_node", 32'(node_a), 32'd0);
        chk("rst_drop", 32'(drop_a), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // basic frame, hand-computed words
        u_bus = BUS_A; rdy_a = 1'b1;
        push_a(2'd0, 18'h1_FFFF, 1'b0);
        push_a(2'd1, 18'h0_0001, 1'b0);
        push_a(2'd2, 18'h0_8000, 1'b0);
        push_a(2'd3, 18'h3_0000, 1'b1);
        pulse_a();
        @(negedge clk);
        chk("lat1_valid", 32'(val_a), 32'd1);
        chk("lat1_node", 32'(node_a), 32'd0);
        @(posedge clk); #1;
        drain_a("frame1");

        // backpressure for 5 cycles at node 1
        push_frame_a(BUS_A);
        pulse_a();
        @(posedge clk); #1;
        rdy_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_node", 32'(node_a), 32'd1);
            chk("hold_data", 32'(data_a), 32'h0_0001);
            @(posedge clk); #1;
        end
        rdy_a = 1'b1;
        drain_a("frame_bp");

        // drops while stalled: first capture wins
        rdy_a = 1'b0;
        push_frame_a(BUS_A);
        pulse_a();
        u_bus = BUS_B;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            pulse_a();
        end
        @(negedge clk);
        chk("drop3", 32'(drop_a), 32'd3);
        @(posedge clk); #1;
        rdy_a = 1'b1;
        drain_a("frame_drop");

        // capture coincident with final handshake
        u_bus = BUS_A;
        push_frame_a(BUS_A);
        push_frame_a(BUS_B);
        pulse_a();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("b2b_valid", 32'(val_a), 32'd1);
            @(posedge clk); #1;
            if (k == 0) u_bus = BUS_B;
            if (k == 2) vin_a = 1'b1;
            if (k == 3) vin_a = 1'b0;
        end
        drain_a("frame_b2b");
        chk("b2b_drop", 32'(drop_a), 32'd3);

        // reset mid-frame
        rdy_a = 1'b0;
        u_bus = BUS_C;
        push_a(2'd0, 18'h0_0909, 1'b0);
        pulse_a();
        rdy_a = 1'b1;
        @(posedge clk); #1;
        rdy_a = 1'b0;
        @(negedge clk);
        chk("pre_rst_node", 32'(node_a), 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(val_a), 32'd0);
        chk("mid_rst_last", 32'(last_a), 32'd0);
        chk("mid_rst_data", 32'(data_a), 32'd0);
        chk("mid_rst_node", 32'(node_a), 32'd0);
        chk("mid_rst_drop", 32'(drop_a), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        u_bus = BUS_D; rdy_a = 1'b1;
        push_frame_a(BUS_D);
        pulse_a();
        drain_a("frame_post_rst");

        // decimated tap mode: captures on pulses 1 and 4
        for (int p = 0; p < 6; p++) begin
            u_bus = {18'h0, tap_vals[p], 18'h0, 18'h0};
            if (p == 0) push_b(18'h0_0111);
            if (p == 3) push_b(18'h2_0444);
            vin_b = 1'b1;
            @(posedge clk); #1;
            vin_b = 1'b0;
            repeat (2) @(posedge clk);
            #1;
        end
        for (int i = 0; i < 50 && (qb.size() != 0 || val_b); i++) begin
            @(posedge clk); #1;
        end
        chk("tap_frames", 32'(qb.size()), 32'd0);
        chk("tap_drop", 32'(drop_b), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
